// File: rtl/adder_arbiter_pkg.sv
// adder_arbiter_pkg: shared types and constants for the adder arbiter.
// The FSM state encoding, the datapath width and the flag bundle live here.
package adder_arbiter_pkg;

  localparam int ADD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic sign;
    logic carry;
    logic zero;
    logic overflow;
  } add_flags_t;

  // Round-robin pointer advance: the slot after the one just served, wrapping.
  function automatic int next_slot(input int cur, input int n);
    return (cur >= n - 1) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/stru_16bitadder.sv
// stru_16bitadder: combinational 16-bit adder with sign/carry/zero/overflow.
// Overflow is the two's-complement case: equal operand signs, different result sign.
module stru_16bitadder (
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] out,
  output logic        sign,
  output logic        carry,
  output logic        zero,
  output logic        overflow
);

  logic [16:0] full;

  assign full     = {1'b0, A} + {1'b0, B};
  assign out      = full[15:0];
  assign carry    = full[16];
  assign sign     = full[15];
  assign zero     = (full[15:0] == 16'h0000);
  assign overflow = (A[15] == B[15]) && (full[15] != A[15]);

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one stru_16bitadder among N_REQ
// requesters. One operation in flight; response held until rsp_ready.
// Optional feature: define ADDARB_STATS_EN to add the op_count port, a
// wrapping count of response handshakes.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | req_ready offered to round-robin winner; accept latches operands
// EXEC  | adder evaluates operand registers; results captured, rr_ptr advanced
// RESP  | rsp_valid high, response held until rsp_ready
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [ADD_W*N_REQ-1:0] req_a,
  input  logic [ADD_W*N_REQ-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [ADD_W-1:0]       rsp_sum,
  output logic                   rsp_sign,
  output logic                   rsp_carry,
  output logic                   rsp_zero,
  output logic                   rsp_overflow
`ifdef ADDARB_STATS_EN
  ,
  output logic [15:0]            op_count
`endif
);

  state_t           state;
  state_t           state_nxt;
  logic [ID_W-1:0]  rr_ptr;

  logic [ADD_W-1:0] op_a;
  logic [ADD_W-1:0] op_b;
  logic [ID_W-1:0]  op_id;

  logic [ADD_W-1:0] add_sum;
  add_flags_t       add_flags;

  add_flags_t       rsp_flags;

  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic [N_REQ-1:0] grant_vec;
  int               cand;

  // Round-robin search from rr_ptr upward, wrapping at N_REQ-1.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_vec   = '0;
    cand        = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % N_REQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found     = 1'b1;
        grant_idx       = ID_W'(cand);
        grant_vec[cand] = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_found) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; req_ready is held low while reset is asserted so that
  // every output reads 0 during reset.
  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    case (state)
      IDLE:    if (rst_n) req_ready = grant_vec;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand capture on accept, result capture and pointer advance in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      rsp_sum   <= '0;
      rsp_flags <= '0;
      rsp_id    <= '0;
      rr_ptr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            op_a  <= req_a[int'(grant_idx)*ADD_W +: ADD_W];
            op_b  <= req_b[int'(grant_idx)*ADD_W +: ADD_W];
            op_id <= grant_idx;
          end
        end
        EXEC: begin
          rsp_sum   <= add_sum;
          rsp_flags <= add_flags;
          rsp_id    <= op_id;
          rr_ptr    <= ID_W'(next_slot(int'(op_id), N_REQ));
        end
        default: ;
      endcase
    end
  end

  stru_16bitadder u_adder (
    .A        (op_a),
    .B        (op_b),
    .out      (add_sum),
    .sign     (add_flags.sign),
    .carry    (add_flags.carry),
    .zero     (add_flags.zero),
    .overflow (add_flags.overflow)
  );

  assign rsp_sign     = rsp_flags.sign;
  assign rsp_carry    = rsp_flags.carry;
  assign rsp_zero     = rsp_flags.zero;
  assign rsp_overflow = rsp_flags.overflow;

`ifdef ADDARB_STATS_EN
  // Count completed response handshakes, wrapping at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (rsp_valid && rsp_ready) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: scoreboard bench for adder_arbiter (N_REQ=4).
module tb_adder_arbiter;

  localparam int N = 4;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [16*N-1:0] req_a;
  logic [16*N-1:0] req_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [15:0]   rsp_sum;
  logic          rsp_sign;
  logic          rsp_carry;
  logic          rsp_zero;
  logic          rsp_overflow;
`ifdef ADDARB_STATS_EN
  logic [15:0]   op_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int exp_ops = 0;
  logic [21:0] sb_q[$];

  adder_arbiter #(.N_REQ(N), .ID_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_sum      (rsp_sum),
    .rsp_sign     (rsp_sign),
    .rsp_carry    (rsp_carry),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow)
`ifdef ADDARB_STATS_EN
    ,
    .op_count     (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [21:0] model(input int id, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return {2'(id), s[15:0], s[15], s[16], (s[15:0] == 16'h0), (a[15] == b[15]) && (s[15] != a[15])};
  endfunction

  function automatic logic [21:0] observed();
    return {rsp_id, rsp_sum, rsp_sign, rsp_carry, rsp_zero, rsp_overflow};
  endfunction

  task automatic test_reset();
    logic [21:0] obs;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    obs = observed();
    n_cmp++;
    if ({obs, rsp_valid, req_ready} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h, required 0", {obs, rsp_valid, req_ready});
    end
    rst_n = 1'b1;
`ifdef ADDARB_STATS_EN
    n_cmp++;
    if (op_count !== 16'd0) begin n_err++; $display("FAIL reset_op_count: got %0d, required 0", op_count); end
`endif
  endtask

  task automatic test_single(input int id, input logic [15:0] a, input logic [15:0] b,
                             input logic [21:0] exp_rsp);
    logic [21:0] e;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = '0; req_valid[id] = 1'b1;
    req_a[id*16 +: 16] = a; req_b[id*16 +: 16] = b;
    #1;
    n_cmp++;
    if (req_ready !== 4'(1 << id)) begin
      n_err++; $display("FAIL single_grant id%0d: got %b, required %b", id, req_ready, 4'(1 << id));
    end
    sb_q.push_back(exp_rsp);
    @(posedge clk); #1;
    req_valid = '0;
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== '0) begin
      n_err++; $display("FAIL single_exec id%0d: rsp_valid=%b req_ready=%b, required 0/0", id, rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (rsp_valid !== 1'b1) begin
      n_err++; $display("FAIL single_latency id%0d: rsp_valid=%b, required 1", id, rsp_valid);
    end
    e = sb_q.pop_front();
    n_cmp++;
    if (observed() !== e) begin
      n_err++; $display("FAIL single_rsp id%0d: got %h, required %h", id, observed(), e);
    end
    @(posedge clk); #1;
    exp_ops++;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL single_done id%0d: rsp_valid=%b, required 0", id, rsp_valid);
    end
`ifdef ADDARB_STATS_EN
    n_cmp++;
    if (op_count !== 16'(exp_ops)) begin n_err++; $display("FAIL single_op_count: got %0d, required %0d", op_count, exp_ops); end
`endif
  endtask

  task automatic test_backpressure();
    logic [21:0] e;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 4'b1000;
    req_a[48 +: 16] = 16'h7fff; req_b[48 +: 16] = 16'h0001;
    #1;
    n_cmp++;
    if (req_ready !== 4'b1000) begin n_err++; $display("FAIL bp_grant: got %b, required 1000", req_ready); end
    sb_q.push_back(model(3, 16'h7fff, 16'h0001));
    @(posedge clk); #1;
    req_valid = 4'b0111;
    @(posedge clk); #1;
    e = sb_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b1 || req_ready !== '0 || observed() !== e) begin
        n_err++;
        $display("FAIL bp_hold cycle%0d: valid=%b ready=%b rsp=%h, required 1/0000/%h", i, rsp_valid, req_ready, observed(), e);
      end
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    exp_ops++;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_release: rsp_valid=%b, required 0", rsp_valid); end
`ifdef ADDARB_STATS_EN
    n_cmp++;
    if (op_count !== 16'(exp_ops)) begin n_err++; $display("FAIL bp_op_count: got %0d, required %0d", op_count, exp_ops); end
`endif
  endtask

  task automatic test_round_robin();
    logic [15:0] opa[N];
    logic [15:0] opb[N];
    logic [21:0] e;
    int grants = 0;
    int resps = 0;
    int upd = -1;
    int g;
    for (int i = 0; i < N; i++) begin
      opa[i] = 16'($urandom); opb[i] = 16'($urandom);
      req_a[i*16 +: 16] = opa[i]; req_b[i*16 +: 16] = opb[i];
    end
    rsp_ready = 1'b1;
    req_valid = 4'hf;
    for (int cyc = 0; cyc < 100 && resps < 8; cyc++) begin
      @(negedge clk);
      if (upd >= 0) begin
        opa[upd] = 16'($urandom); opb[upd] = 16'($urandom);
        req_a[upd*16 +: 16] = opa[upd]; req_b[upd*16 +: 16] = opb[upd];
        upd = -1;
      end
      if (grants >= 8) req_valid = '0;
      #1;
      n_cmp++;
      if ($countones(req_ready) > 1) begin n_err++; $display("FAIL rr_onehot: req_ready=%b, required at most one bit", req_ready); end
      if (req_ready != '0) begin
        g = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        n_cmp++;
        if (g !== grants % N) begin n_err++; $display("FAIL rr_order grant%0d: got %0d, required %0d", grants, g, grants % N); end
        sb_q.push_back(model(g, opa[g], opb[g]));
        grants++;
        upd = g;
      end
      if (rsp_valid) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++; $display("FAIL rr_rsp: got %h, required no response", observed());
        end else begin
          e = sb_q.pop_front();
          if (observed() !== e) begin n_err++; $display("FAIL rr_rsp%0d: got %h, required %h", resps, observed(), e); end
        end
        resps++;
        exp_ops++;
      end
    end
    n_cmp++;
    if (resps != 8) begin n_err++; $display("FAIL rr_count: got %0d responses, required 8", resps); end
  endtask

  task automatic test_reset_in_exec();
    logic [21:0] e;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 4'b0100;
    req_a[32 +: 16] = 16'h1234; req_b[32 +: 16] = 16'h4321;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin n_err++; $display("FAIL rst_pre_grant: got %b, required 0100", req_ready); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_valid = 4'b1010;
    req_a[16 +: 16] = 16'h0001; req_b[16 +: 16] = 16'hffff;
    #1;
    n_cmp++;
    if ({observed(), rsp_valid, req_ready} !== '0) begin
      n_err++; $display("FAIL rst_exec_outputs: got %h, required 0", {observed(), rsp_valid, req_ready});
    end
    repeat (2) @(posedge clk);
    exp_ops = 0;
`ifdef ADDARB_STATS_EN
    n_cmp++;
    if (op_count !== 16'd0) begin n_err++; $display("FAIL rst_op_count: got %0d, required 0", op_count); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rst_next_grant: got %b, required 0010", req_ready); end
    sb_q.push_back(model(1, 16'h0001, 16'hffff));
    @(posedge clk); #1;
    req_valid = '0;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_no_stale_rsp: rsp_valid=%b, required 0", rsp_valid); end
    @(posedge clk); #1;
    e = sb_q.pop_front();
    n_cmp++;
    if (rsp_valid !== 1'b1 || observed() !== e) begin
      n_err++; $display("FAIL rst_after_rsp: valid=%b rsp=%h, required 1/%h", rsp_valid, observed(), e);
    end
    @(posedge clk); #1;
    exp_ops++;
`ifdef ADDARB_STATS_EN
    n_cmp++;
    if (op_count !== 16'(exp_ops)) begin n_err++; $display("FAIL rst_op_count_after: got %0d, required %0d", op_count, exp_ops); end
`endif
    n_cmp++;
    if (sb_q.size() != 0) begin n_err++; $display("FAIL sb_drain: %0d left, required 0", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    // {id, sum, sign, carry, zero, overflow}
    test_single(0, 16'h8fff, 16'h8000, {2'd0, 16'h0fff, 1'b0, 1'b1, 1'b0, 1'b1});
    test_single(2, 16'hfffe, 16'h0002, {2'd2, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0});
    test_single(1, 16'haaaa, 16'h5555, {2'd1, 16'hffff, 1'b1, 1'b0, 1'b0, 1'b0});
    test_backpressure();
    test_round_robin();
    test_reset_in_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Shares one `stru_16bitadder` instance between `N_REQ` requesters. Each requester uses a valid/ready handshake, and grants are issued in round-robin order. Operands are registered into the adder, and the sum and its four flags are returned with the requester ID on a response port that supports backpressure. The block sits between client datapaths and the shared adder and is the only block that drives the adder's inputs.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default 2: response ID width, equal to $clog2(N_REQ).
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `req_valid`  in  N_REQ: request valid, one bit per requester.
- `req_ready`  out  N_REQ: grant/accept, one-hot or zero.
- `req_a`  in  16*N_REQ: operand A. Requester i occupies bits [16i+15:16i].
- `req_b`  in  16*N_REQ: operand B, same packing as `req_a`.
- `rsp_valid`  out  1: response valid.
- `rsp_ready`  in  1: consumer accepts the response.
- `rsp_id`  out  ID_W: index of the requester that owns the response.
- `rsp_sum`  out  16: A+B mod 2^16.
- `rsp_sign`, `rsp_carry`, `rsp_zero`, `rsp_overflow`  out  1 each: adder flags.
- `op_count`  out  16: completed-operation count. Present only with `ADDARB_STATS_EN`.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - `req_ready` is combinational. It is one-hot on the first requester with `req_valid`=1, searching from `rr_ptr` upward and wrapping at N_REQ-1 to 0.
  - On a handshake, latch A, B and the ID into the operand registers, then go to EXEC.
  - If no `req_valid` is set, stay in IDLE.
- EXEC:
  - The adder evaluates the registered operands.
  - Capture sum, flags and ID into the response registers.
  - Set `rr_ptr` to granted ID + 1, wrapping. Go to RESP.
- RESP:
  - `rsp_valid`=1 and all response outputs are stable.
  - On `rsp_valid && rsp_ready`, go to IDLE. Otherwise hold.
- `req_ready` is 0 in EXEC and RESP. There is never more than one request in flight.
- Flags:
  - sign = sum[15].
  - carry = carry out of bit 15.
  - zero = (sum == 0).
  - overflow = (A[15]==B[15]) && (sum[15]!=A[15]).
- A requester may deassert `req_valid` without being granted. No state is kept for requests that were not granted.
- When several requesters are valid at once, only the one chosen by the round-robin search is granted. The others see `req_ready`=0.
- Reset (async, any state):
  - State goes to IDLE and `rr_ptr` to 0.
  - Operand and response registers go to 0, and `rsp_valid`=0.
  - An in-flight operation is discarded and no response is issued.

## Timing
- Handshake at edge T (IDLE). Response registers are loaded at edge T+1 (EXEC). `rsp_valid`=1 from after edge T+1.
- Minimum latency from request accept to `rsp_valid` is one cycle.
- If `rsp_ready` is 1 in the first RESP cycle, the block is back in IDLE after edge T+2. The next grant can occur at edge T+3.
- Peak throughput is one operation per 3 cycles.
- The stall in RESP is unbounded. The response outputs do not change while `rsp_valid`=1 and `rsp_ready`=0.
- `req_ready` depends combinationally on `req_valid` and the state. There is no combinational path from `rsp_ready` to `req_ready`.
- Reset values of all outputs are 0. Because `rr_ptr` resets to 0, the first grant goes to the lowest-index valid requester.

## Configuration
- `ADDARB_STATS_EN` defined:
  - Port `op_count` exists.
  - It resets to 0 and increments by 1 on each response handshake.
  - It wraps from 16'hffff to 16'h0000.
- Not defined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Package `adder_arbiter_pkg` holds:
  - The state enum (IDLE, EXEC, RESP).
  - The constant `ADD_W`=16.
  - A packed struct `add_flags_t` {sign, carry, zero, overflow}.
- Sub-module: the existing `stru_16bitadder`, instantiated once on the operand registers. Its ports in order are A, B, out, sign, carry, zero, overflow.
- Round-robin selection and the FSM are inline in `adder_arbiter`. No other sub-module is used.

## Test plan
- Single request: requester 0 sends A=8fff, B=8000 with `rsp_ready`=1.
  - Required response: `rsp_valid` one cycle after accept; sum=0fff, id=0, sign=0, carry=1, zero=0, overflow=1.
- Requester 2 sends A=fffe, B=0002.
  - Required response: sum=0000, carry=1, zero=1, sign=0, overflow=0, id=2.
- Requester 1 sends A=aaaa, B=5555.
  - Required response: sum=ffff, sign=1, carry=0, zero=0, overflow=0.
- All 4 requesters hold valid continuously for 8 operations.
  - Required grant order: 0, 1, 2, 3, 0, 1, 2, 3. `req_ready` is never multi-hot.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP.
  - Required: outputs stable, `req_ready`=0 throughout. One handshake occurs when `rsp_ready` rises, then the block returns to IDLE.
- Assert `rst_n`=0 during EXEC.
  - Required: all outputs 0 immediately, no response issued, next grant goes to the lowest valid index. With `ADDARB_STATS_EN`, `op_count`=0 after reset and equals the number of completed handshakes.
